// File: rtl/icache_pkg.sv
// Shared types for the set-associative instruction cache: state encoding, address layout, victim choice.
package icache_pkg;

    localparam int ICACHE_NSETS    = 8;
    localparam int ICACHE_NWAYS    = 2;
    localparam int ICACHE_BLKWORDS = 2;
    localparam int ICACHE_BOFF_W   = $clog2(ICACHE_BLKWORDS);
    localparam int ICACHE_IDX_W    = $clog2(ICACHE_NSETS);
    localparam int ICACHE_TAG_W    = 30 - ICACHE_IDX_W - ICACHE_BOFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } icache_state_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0]  tag;
        logic [ICACHE_IDX_W-1:0]  idx;
        logic [ICACHE_BOFF_W-1:0] boff;
        logic [1:0]               bytoff;
    } icache_addr_t;

    // Lowest invalid way wins; otherwise LRU bit (2 ways) or round-robin pointer (4 ways).
    function automatic logic [1:0] victim_sel(input logic [3:0] valid, input int nways,
                                              input logic lru, input logic [1:0] rr);
        logic [1:0] v;
        logic       found;
        v     = 2'd0;
        found = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (w < nways && !valid[w] && !found) begin
                v     = w[1:0];
                found = 1'b1;
            end
        end
        if (!found) begin
            if (nways == 2)      v = {1'b0, lru};
            else if (nways == 4) v = rr;
            else                 v = 2'd0;
        end
        return v;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid/tag and block data; combinational read, single fill write port.
// Valid clear (fill start or flush) and valid set (fill end) never coincide on the same set.
module icache_way #(
    parameter int NSETS    = 8,
    parameter int BLKWORDS = 2,
    parameter int TAG_W    = 26,
    parameter int IDX_W    = 3,
    parameter int BW       = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [BW-1:0]    rd_boff,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic             wr_en,
    input  logic [BW-1:0]    wr_boff,
    input  logic [31:0]      wr_data,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic             valid [NSETS];
    logic [TAG_W-1:0] tag   [NSETS];
    logic [31:0]      data  [NSETS][BLKWORDS];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag[rd_idx];
    assign rd_data  = data[rd_idx][rd_boff];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < NSETS; s++) begin
                valid[s] <= 1'b0;
                tag[s]   <= '0;
                for (int b = 0; b < BLKWORDS; b++) begin
                    data[s][b] <= '0;
                end
            end
        end else begin
            if (clr_en) begin
                valid[clr_idx] <= 1'b0;
            end
            if (wr_en) begin
                data[fill_idx][wr_boff] <= wr_data;
            end
            if (set_en) begin
                valid[fill_idx] <= 1'b1;
                tag[fill_idx]   <= set_tag;
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative icache: combinational hit, burst block fill on miss, one-set-per-cycle flush.
// Hit and fill start yield to dmem_busy; fill words advance only when iwait is low.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int NSETS    = ICACHE_NSETS,
    parameter int NWAYS    = ICACHE_NWAYS,
    parameter int BLKWORDS = ICACHE_BLKWORDS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmem_busy,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        flush_busy,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int BOFF_W = $clog2(BLKWORDS);
    localparam int IDX_W  = $clog2(NSETS);
    localparam int TAG_W  = 30 - IDX_W - BOFF_W;
    localparam int BW     = (BOFF_W == 0) ? 1 : BOFF_W;

    icache_state_t    state, next_state;
    logic [TAG_W-1:0] ltag;
    logic [IDX_W-1:0] lidx;
    logic [BW-1:0]    wcnt;
    logic [1:0]       victim;
    logic             flush_pend;
    logic [IDX_W-1:0] fcnt;
    logic [31:0]      iaddr_hold;
    logic             lru [NSETS];
    logic [1:0]       rr  [NSETS];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [BW-1:0]    req_boff;
    logic [IDX_W-1:0] rd_idx;

    logic             rd_valid [NWAYS];
    logic [TAG_W-1:0] rd_tag   [NWAYS];
    logic [31:0]      rd_data  [NWAYS];
    logic [NWAYS-1:0] hit_w;
    logic             any_hit;
    logic [1:0]       hw;
    logic [31:0]      hit_data;
    logic [3:0]       vvec;
    logic [1:0]       vsel;

    logic             fill_start, wr_any, set_any, clr_all, last_word;
    logic [IDX_W-1:0] clr_idx;
    logic [31:0]      fill_addr;

    assign req_tag  = imemaddr[31 -: TAG_W];
    assign req_idx  = imemaddr[2 + BOFF_W +: IDX_W];
    assign req_boff = (BLKWORDS > 1) ? imemaddr[2 +: BW] : '0;
    assign rd_idx   = req_idx;

    assign last_word = (wcnt == BW'(BLKWORDS - 1));
    assign fill_addr = (32'({ltag, lidx}) << (BOFF_W + 2)) | (32'(wcnt) << 2);

    genvar gw;
    generate
        for (gw = 0; gw < NWAYS; gw++) begin : g_way
            icache_way #(
                .NSETS(NSETS), .BLKWORDS(BLKWORDS), .TAG_W(TAG_W), .IDX_W(IDX_W), .BW(BW)
            ) u_way (
                .CLK     (CLK),
                .RST     (RST),
                .rd_idx  (rd_idx),
                .rd_boff (req_boff),
                .rd_valid(rd_valid[gw]),
                .rd_tag  (rd_tag[gw]),
                .rd_data (rd_data[gw]),
                .fill_idx(lidx),
                .wr_en   (wr_any && victim == 2'(gw)),
                .wr_boff (wcnt),
                .wr_data (iload),
                .set_en  (set_any && victim == 2'(gw)),
                .set_tag (ltag),
                .clr_en  (clr_all || (fill_start && vsel == 2'(gw))),
                .clr_idx (clr_idx)
            );
            assign hit_w[gw] = rd_valid[gw] && (rd_tag[gw] == req_tag);
        end
    endgenerate

    assign any_hit = |hit_w;

    // Fill guarantees a single hitting way, so an OR-mux is sufficient.
    always_comb begin
        hw       = 2'd0;
        hit_data = '0;
        vvec     = 4'hF;
        for (int w = 0; w < NWAYS; w++) begin
            if (hit_w[w]) begin
                hw       = 2'(w);
                hit_data = hit_data | rd_data[w];
            end
            vvec[w] = rd_valid[w];
        end
        vsel = victim_sel(vvec, NWAYS, lru[req_idx], rr[req_idx]);
    end

    assign ihit       = (state == IDLE) && imemREN && !dmem_busy && any_hit;
    assign imemload   = ihit ? hit_data : 32'd0;
    assign iREN       = (state == FILL);
    assign iaddr      = (state == FILL) ? fill_addr : iaddr_hold;
    assign flush_busy = (state == FLUSH) || flush_pend || flush;

    always_comb begin
        next_state = state;
        fill_start = 1'b0;
        wr_any     = 1'b0;
        set_any    = 1'b0;
        clr_all    = 1'b0;
        clr_idx    = req_idx;
        case (state)
            IDLE: begin
                if (flush) begin
                    next_state = FLUSH;
                end else if (imemREN && !dmem_busy && !any_hit) begin
                    next_state = FILL;
                    fill_start = 1'b1;
                end
            end
            FILL: begin
                if (!iwait) begin
                    wr_any = 1'b1;
                    if (last_word) begin
                        set_any    = 1'b1;
                        next_state = (flush_pend || flush) ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                clr_all = 1'b1;
                clr_idx = fcnt;
                if (fcnt == IDX_W'(NSETS - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            ltag       <= '0;
            lidx       <= '0;
            wcnt       <= '0;
            victim     <= 2'd0;
            flush_pend <= 1'b0;
            fcnt       <= '0;
            iaddr_hold <= '0;
            for (int s = 0; s < NSETS; s++) begin
                lru[s] <= 1'b0;
                rr[s]  <= 2'd0;
            end
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    fcnt <= '0;
                    if (ihit) begin
                        lru[req_idx] <= ~hw[0];
                    end
                    if (fill_start) begin
                        ltag            <= req_tag;
                        lidx            <= req_idx;
                        victim          <= vsel;
                        wcnt            <= '0;
                        rr[req_idx]     <= rr[req_idx] + 2'd1;
                    end
                end
                FILL: begin
                    iaddr_hold <= fill_addr;
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (!iwait) begin
                        wcnt <= wcnt + 1'b1;
                        if (last_word) begin
                            lru[lidx]  <= ~victim[0];
                            flush_pend <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed and randomized fetches against a recency-list cache model with a behavioural memory.
module tb_icache_assoc;
    import icache_pkg::*;

    localparam int NSETS     = ICACHE_NSETS;
    localparam int NWAYS     = ICACHE_NWAYS;
    localparam int BLKWORDS  = ICACHE_BLKWORDS;
    localparam int BLK_BYTES = BLKWORDS * 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmem_busy;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush_busy;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks   = 0;
    int failures = 0;

    // Resident tags per set, most recently used first.
    int unsigned rtag [NSETS][NWAYS];
    int          rcnt [NSETS];

    icache_assoc dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .dmem_busy(dmem_busy),
        .flush(flush), .ihit(ihit), .imemload(imemload), .flush_busy(flush_busy), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a >> 2) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_find(input int idx, input int unsigned tag);
        for (int p = 0; p < rcnt[idx]; p++) begin
            if (rtag[idx][p] == tag) return p;
        end
        return -1;
    endfunction

    task automatic model_touch(input int idx, input int pos);
        int unsigned t;
        t = rtag[idx][pos];
        for (int p = pos; p > 0; p--) rtag[idx][p] = rtag[idx][p-1];
        rtag[idx][0] = t;
    endtask

    task automatic model_insert(input int idx, input int unsigned tag);
        if (rcnt[idx] < NWAYS) rcnt[idx]++;
        for (int p = rcnt[idx] - 1; p > 0; p--) rtag[idx][p] = rtag[idx][p-1];
        rtag[idx][0] = tag;
    endtask

    task automatic model_clear();
        for (int s = 0; s < NSETS; s++) rcnt[s] = 0;
    endtask

    // wt_fix < 0 picks random wait states; flush_word >= 0 pulses flush on that word's first cycle.
    task automatic fetch(input logic [31:0] addr, input int wt_fix, input int flush_word,
                         output bit was_hit);
        icache_addr_t a;
        int           pos;
        int           wt;
        bit           flushed;
        logic [31:0]  base;
        a       = addr;
        base    = addr & ~32'(BLK_BYTES - 1);
        pos     = model_find(int'(a.idx), int'(a.tag));
        was_hit = (pos >= 0);
        flushed = 1'b0;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        iload    = $urandom;
        #1;
        if (was_hit) begin
            chk("hit", 32'(ihit), 32'd1);
            chk("hit_data", imemload, mem(addr));
            chk("hit_no_iren", 32'(iREN), 32'd0);
            model_touch(int'(a.idx), pos);
            @(posedge CLK);
        end else begin
            chk("miss_no_hit", 32'(ihit), 32'd0);
            chk("miss_no_iren", 32'(iREN), 32'd0);
            @(posedge CLK);
            for (int k = 0; k < BLKWORDS; k++) begin
                wt = (wt_fix >= 0) ? wt_fix : int'($urandom_range(0, 2));
                for (int j = 0; j <= wt; j++) begin
                    @(negedge CLK);
                    iwait = (j < wt);
                    iload = (j == wt) ? mem(base + 32'(4 * k)) : $urandom;
                    flush = (k == flush_word && j == 0);
                    if (flush) flushed = 1'b1;
                    #1;
                    chk("fill_iren", 32'(iREN), 32'd1);
                    chk("fill_iaddr", iaddr, base + 32'(4 * k));
                    chk("fill_no_hit", 32'(ihit), 32'd0);
                    if (flushed) chk("fill_flush_busy", 32'(flush_busy), 32'd1);
                    @(posedge CLK);
                end
            end
            model_insert(int'(a.idx), int'(a.tag));
            @(negedge CLK);
            flush = 1'b0;
            iwait = 1'b1;
            if (flushed) begin
                imemREN = 1'b0;
                model_clear();
                for (int s = 0; s < NSETS; s++) begin
                    if (s > 0) @(negedge CLK);
                    #1;
                    chk("post_fill_flush_busy", 32'(flush_busy), 32'd1);
                    chk("post_fill_flush_no_hit", 32'(ihit), 32'd0);
                    chk("post_fill_flush_no_iren", 32'(iREN), 32'd0);
                    @(posedge CLK);
                end
                @(negedge CLK);
                #1;
                chk("post_fill_flush_done", 32'(flush_busy), 32'd0);
            end else begin
                #1;
                chk("fill_done_hit", 32'(ihit), 32'd1);
                chk("fill_done_data", imemload, mem(addr));
                chk("fill_done_no_iren", 32'(iREN), 32'd0);
                chk("iaddr_hold", iaddr, base + 32'(BLK_BYTES - 4));
                @(posedge CLK);
            end
        end
        @(negedge CLK);
        imemREN = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        bit h;
        logic [31:0] ra;
        RST       = 1'b1;
        imemREN   = 1'b0;
        imemaddr  = '0;
        dmem_busy = 1'b0;
        flush     = 1'b0;
        iwait     = 1'b1;
        iload     = '0;
        model_clear();

        @(negedge CLK);
        #1;
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iren", 32'(iREN), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_flush_busy", 32'(flush_busy), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        fetch(32'h0000_0040, 2, -1, h);
        chk("cold_0x40_miss", 32'(h), 32'd0);
        fetch(32'h0000_0044, 0, -1, h);
        chk("same_block_0x44_hit", 32'(h), 32'd1);

        // Three tags competing for one set, with the oldest line touched in between.
        fetch(32'h0000_0140, -1, -1, h);
        chk("conf_0x140_miss", 32'(h), 32'd0);
        fetch(32'h0000_0040, -1, -1, h);
        chk("conf_0x040_touch", 32'(h), 32'd1);
        fetch(32'h0000_0240, -1, -1, h);
        chk("conf_0x240_miss", 32'(h), 32'd0);
        fetch(32'h0000_0040, -1, -1, h);
        chk("conf_0x040_kept", 32'(h), 32'd1);
        fetch(32'h0000_0140, -1, -1, h);
        chk("conf_0x140_evicted", 32'(h), 32'd0);

        @(negedge CLK);
        imemREN   = 1'b1;
        imemaddr  = 32'h0000_0044;
        dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            chk("dbusy_no_hit", 32'(ihit), 32'd0);
            chk("dbusy_no_iren", 32'(iREN), 32'd0);
            @(posedge CLK);
        end
        @(negedge CLK);
        dmem_busy = 1'b0;
        #1;
        chk("dbusy_release_hit", 32'(ihit), 32'd1);
        chk("dbusy_release_data", imemload, mem(32'h0000_0044));
        model_touch(0, model_find(0, 32'd1));
        @(posedge CLK);
        @(negedge CLK);
        imemREN = 1'b0;

        fetch(32'h0000_0008, -1, -1, h);
        @(negedge CLK);
        flush = 1'b1;
        #1;
        chk("flush_pulse_busy", 32'(flush_busy), 32'd1);
        @(posedge CLK);
        for (int i = 0; i < NSETS; i++) begin
            @(negedge CLK);
            flush = 1'b0;
            #1;
            chk("flush_busy", 32'(flush_busy), 32'd1);
            chk("flush_no_iren", 32'(iREN), 32'd0);
            @(posedge CLK);
        end
        @(negedge CLK);
        #1;
        chk("flush_done", 32'(flush_busy), 32'd0);
        model_clear();
        fetch(32'h0000_0040, -1, -1, h);
        chk("postflush_0x40_miss", 32'(h), 32'd0);
        fetch(32'h0000_0140, -1, -1, h);
        chk("postflush_0x140_miss", 32'(h), 32'd0);
        fetch(32'h0000_0008, -1, -1, h);
        chk("postflush_0x08_miss", 32'(h), 32'd0);

        fetch(32'h0000_0080, 1, 0, h);
        fetch(32'h0000_0080, -1, -1, h);
        chk("fill_flush_0x80_miss", 32'(h), 32'd0);

        // Reset while the second word of a fill is outstanding.
        fetch(32'h0000_0040, -1, -1, h);
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        iwait    = 1'b1;
        #1;
        chk("rstfill_miss", 32'(ihit), 32'd0);
        @(negedge CLK);
        iwait = 1'b0;
        iload = mem(32'h0000_0100);
        #1;
        chk("rstfill_w0_addr", iaddr, 32'h0000_0100);
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        chk("rstfill_w1_iren", 32'(iREN), 32'd1);
        chk("rstfill_w1_addr", iaddr, 32'h0000_0104);
        RST = 1'b1;
        #1;
        chk("rstfill_iren_drop", 32'(iREN), 32'd0);
        chk("rstfill_iaddr_zero", iaddr, 32'd0);
        @(negedge CLK);
        RST     = 1'b0;
        imemREN = 1'b0;
        model_clear();
        fetch(32'h0000_0100, -1, -1, h);
        chk("rstfill_0x100_miss", 32'(h), 32'd0);
        fetch(32'h0000_0040, -1, -1, h);
        chk("rstfill_0x40_miss", 32'(h), 32'd0);

        for (int n = 0; n < 120; n++) begin
            ra = ($urandom_range(0, 3) << 6) | ($urandom_range(0, NSETS - 1) << 3)
               | ($urandom_range(0, BLKWORDS - 1) << 2);
            fetch(ra, -1, -1, h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
